fetch_unit: RTL and testbench

Parametrised instruction-fetch stage with its own program counter, on-chip instruction memory, and a prefetch FIFO toward decode. It generates sequential PCs, reads one word per cycle, and buffers instruction/PC pairs behind a valid/ready handshake. A redirect port serves branches and exceptions: it reloads the PC and squashes all buffered and in-flight fetches. It sits at the head of the MCU-32X pipeline, feeding decode.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
// Contents: FETCH_XLEN entry width, DEFAULT_RESET_PC, PC_INCR, fetch_entry_t {pc, instr, fault}.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int PC_INCR = 4;

    // One prefetch FIFO slot. fault is only ever set by the alignment
    // checker (FETCH_ALIGN_CHECK_EN); otherwise it stays 0.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-to-decode handshake bundle
// Signals: out_valid/out_ready handshake, out_instr, out_pc, and out_fault
// (present only when FETCH_ALIGN_CHECK_EN is defined).
// Modports: master (fetch side drives instruction), slave (decode side drives ready).
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            out_fault;

    modport master (output out_valid, output out_instr, output out_pc,
                    output out_fault, input out_ready);
    modport slave  (input out_valid, input out_instr, input out_pc,
                    input out_fault, output out_ready);
`else
    modport master (output out_valid, output out_instr, output out_pc,
                    input out_ready);
    modport slave  (input out_valid, input out_instr, input out_pc,
                    output out_ready);
`endif
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of fetch_entry_t with synchronous flush
// Ports: clk, reset (async, active-high), flush, push, push_entry, pop,
// head (entry at read pointer), count (entries held). DEPTH must be a power of two >= 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // A push alongside a flush lands in a freshly emptied FIFO;
            // this is how the alignment fault entry gets in.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (push) begin
                mem_d[0] = push_entry;
                wr_ptr_d = PW'(1);
                count_d  = CW'(1);
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push && !pop) begin
            assert (count_q != CW'(DEPTH));
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, instruction memory, in-flight read, prefetch FIFO
// Ports: clk, reset (async, active-high), redirect_valid/redirect_pc (reload PC and flush),
// imem_we/imem_waddr/imem_wdata (memory loader), dec (fetch_unit_if.master toward decode).
// Build option: FETCH_ALIGN_CHECK_EN adds out_fault and halts fetch on a misaligned redirect;
// without it redirect_pc[1:0] is ignored.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN,
    parameter int IMEM_DEPTH = 1024,
    parameter int FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            imem_we,
    input  logic [AW-1:0]   imem_waddr,
    input  logic [XLEN-1:0] imem_wdata,
    fetch_unit_if.master    dec
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] imem [IMEM_DEPTH];

    logic            pop;
    logic            issue;
    logic            push;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] redirect_target;
    logic            fetch_enable;

`ifdef FETCH_ALIGN_CHECK_EN
    logic halted_q, halted_d;
    logic redirect_misaligned;

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_target     = redirect_pc;
    assign fetch_enable        = !halted_q;
    assign halted_d            = redirect_valid ? redirect_misaligned : halted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    logic [1:0] unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign fetch_enable        = 1'b1;
`endif

    assign pop = dec.out_valid & dec.out_ready;

    // Slots already spoken for: buffered entries plus the read in flight,
    // less the one leaving this cycle. Issue only if a slot is left.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign issue     = !redirect_valid && fetch_enable && (occupancy < (CW + 1)'(FIFO_DEPTH));

    always_comb begin
        push       = inflight_q && !redirect_valid;
        push_entry = '{pc: inflight_pc_q, instr: rdata_q, fault: 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_misaligned) begin
            push       = 1'b1;
            push_entry = '{pc: redirect_pc, instr: '0, fault: 1'b1};
        end
`endif
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + XLEN'(PC_INCR);
            inflight_pc_d = fetch_pc_q;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    // Memory array and its read register are not reset so they map onto
    // block RAM; a same-edge write/read of one word returns the old data.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
        if (issue) begin
            rdata_q <= imem[fetch_pc_q[AW+1:2]];
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign dec.out_valid = (count != '0);
    assign dec.out_pc    = head.pc;
    assign dec.out_instr = head.instr;
`ifdef FETCH_ALIGN_CHECK_EN
    assign dec.out_fault = head.fault;
`else
    logic unused_head_fault;

    assign unused_head_fault = head.fault;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;

    int passed;
    int total;

    fetch_unit_if #(.XLEN(32)) dif ();

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .dec            (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dif.out_ready  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 10'(i);
            imem_wdata = 32'hA000_0000 + 32'(i);
            step();
        end
        imem_we = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (dif.out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", dif.out_valid); else passed++;
        total++; if (dif.out_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", dif.out_instr); else passed++;
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (dif.out_fault !== 1'b0) $display("FAIL reset_fault got %0b want 0", dif.out_fault); else passed++;
`endif
    endtask

    task automatic test_stream();
        dif.out_ready = 1'b1;
        reset         = 1'b0;
        step();
        total++; if (dif.out_valid !== 1'b0) $display("FAIL stream_e0_valid got %0b want 0", dif.out_valid); else passed++;
        step();
        for (int i = 0; i < 8; i++) begin
            total++; if (dif.out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0b want 1", i, dif.out_valid); else passed++;
            total++; if (dif.out_pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h want %h", i, dif.out_pc, 32'(4 * i)); else passed++;
            total++; if (dif.out_instr !== 32'hA000_0000 + 32'(i)) $display("FAIL stream_instr[%0d] got %h want %h", i, dif.out_instr, 32'hA000_0000 + 32'(i)); else passed++;
            step();
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        total++; if (dif.out_valid !== 1'b0) $display("FAIL async_reset_valid got %0b want 0", dif.out_valid); else passed++;
        total++; if (dif.out_pc !== 32'h0) $display("FAIL async_reset_pc got %h want 0", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'h0) $display("FAIL async_reset_instr got %h want 0", dif.out_instr); else passed++;
        step();
    endtask

    task automatic test_backpressure();
        dif.out_ready = 1'b0;
        reset         = 1'b0;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            total++; if (dif.out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %0b want 1", i, dif.out_valid); else passed++;
            total++; if (dif.out_pc !== 32'h0) $display("FAIL bp_hold_pc[%0d] got %h want 0", i, dif.out_pc); else passed++;
            step();
        end
        total++; if (dut.u_fifo.count_q !== 2'd2) $display("FAIL bp_count got %0d want 2", dut.u_fifo.count_q); else passed++;
        total++; if (dut.fetch_pc_q !== 32'h8) $display("FAIL bp_fetch_pc got %h want 8", dut.fetch_pc_q); else passed++;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (dif.out_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d] got %0b want 1", i, dif.out_valid); else passed++;
            total++; if (dif.out_pc !== 32'(4 * i)) $display("FAIL bp_drain_pc[%0d] got %h want %h", i, dif.out_pc, 32'(4 * i)); else passed++;
            step();
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_redirect_full();
        dif.out_ready = 1'b0;
        reset         = 1'b0;
        step();
        step();
        total++; if (dut.inflight_q !== 1'b1) $display("FAIL rf_inflight got %0b want 1", dut.inflight_q); else passed++;
        redirect_to(32'h100);
        total++; if (dif.out_valid !== 1'b0) $display("FAIL rf_bubble0 got %0b want 0", dif.out_valid); else passed++;
        step();
        total++; if (dif.out_valid !== 1'b0) $display("FAIL rf_bubble1 got %0b want 0", dif.out_valid); else passed++;
        step();
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (dif.out_valid !== 1'b1) $display("FAIL rf_valid[%0d] got %0b want 1", i, dif.out_valid); else passed++;
            total++; if (dif.out_pc !== 32'h100 + 32'(4 * i)) $display("FAIL rf_pc[%0d] got %h want %h", i, dif.out_pc, 32'h100 + 32'(4 * i)); else passed++;
            total++; if (dif.out_instr !== 32'hA000_0040 + 32'(i)) $display("FAIL rf_instr[%0d] got %h want %h", i, dif.out_instr, 32'hA000_0040 + 32'(i)); else passed++;
            step();
        end
    endtask

    task automatic test_redirect_pop();
        // Head is 0x10C with out_ready high: it is accepted on the redirect edge.
        total++; if (dif.out_pc !== 32'h10C) $display("FAIL rp_head got %h want 10c", dif.out_pc); else passed++;
        redirect_to(32'h40);
        total++; if (dif.out_valid !== 1'b0) $display("FAIL rp_bubble0 got %0b want 0", dif.out_valid); else passed++;
        step();
        total++; if (dif.out_valid !== 1'b0) $display("FAIL rp_bubble1 got %0b want 0", dif.out_valid); else passed++;
        step();
        total++; if (dif.out_valid !== 1'b1) $display("FAIL rp_valid got %0b want 1", dif.out_valid); else passed++;
        total++; if (dif.out_pc !== 32'h40) $display("FAIL rp_pc got %h want 40", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'hA000_0010) $display("FAIL rp_instr got %h want a0000010", dif.out_instr); else passed++;
        step();
        total++; if (dif.out_pc !== 32'h44) $display("FAIL rp_next_pc got %h want 44", dif.out_pc); else passed++;
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        step();
        step();
        total++; if (dif.out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got %h want fffffffc", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'hA000_03FF) $display("FAIL wrap_instr0 got %h want a00003ff", dif.out_instr); else passed++;
        step();
        total++; if (dif.out_valid !== 1'b1) $display("FAIL wrap_valid1 got %0b want 1", dif.out_valid); else passed++;
        total++; if (dif.out_pc !== 32'h0) $display("FAIL wrap_pc1 got %h want 0", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'hA000_0000) $display("FAIL wrap_instr1 got %h want a0000000", dif.out_instr); else passed++;
        step();
        total++; if (dif.out_pc !== 32'h4) $display("FAIL wrap_pc2 got %h want 4", dif.out_pc); else passed++;
    endtask

    task automatic test_align();
        redirect_to(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (dif.out_valid !== 1'b1) $display("FAIL align_fault_valid got %0b want 1", dif.out_valid); else passed++;
        total++; if (dif.out_fault !== 1'b1) $display("FAIL align_fault got %0b want 1", dif.out_fault); else passed++;
        total++; if (dif.out_pc !== 32'h102) $display("FAIL align_fault_pc got %h want 102", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'h0) $display("FAIL align_fault_instr got %h want 0", dif.out_instr); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (dif.out_valid !== 1'b0) $display("FAIL align_halted[%0d] got %0b want 0", i, dif.out_valid); else passed++;
        end
        redirect_to(32'h200);
        step();
        step();
        total++; if (dif.out_valid !== 1'b1) $display("FAIL align_resume_valid got %0b want 1", dif.out_valid); else passed++;
        total++; if (dif.out_fault !== 1'b0) $display("FAIL align_resume_fault got %0b want 0", dif.out_fault); else passed++;
        total++; if (dif.out_pc !== 32'h200) $display("FAIL align_resume_pc got %h want 200", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'hA000_0080) $display("FAIL align_resume_instr got %h want a0000080", dif.out_instr); else passed++;
`else
        step();
        step();
        total++; if (dif.out_valid !== 1'b1) $display("FAIL mask_valid got %0b want 1", dif.out_valid); else passed++;
        total++; if (dif.out_pc !== 32'h100) $display("FAIL mask_pc got %h want 100", dif.out_pc); else passed++;
        total++; if (dif.out_instr !== 32'hA000_0040) $display("FAIL mask_instr got %h want a0000040", dif.out_instr); else passed++;
`endif
    endtask

    task automatic test_mem_write();
        reset = 1'b1;
        step();
        dif.out_ready = 1'b0;
        reset         = 1'b0;
        imem_we       = 1'b1;
        imem_waddr    = 10'd0;
        imem_wdata    = 32'h1234_5678;
        step();
        imem_we = 1'b0;
        step();
        total++; if (dif.out_instr !== 32'hA000_0000) $display("FAIL memwr_old got %h want a0000000", dif.out_instr); else passed++;
        redirect_to(32'h0);
        step();
        step();
        total++; if (dif.out_instr !== 32'h1234_5678) $display("FAIL memwr_new got %h want 12345678", dif.out_instr); else passed++;
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        preload();
        test_reset();
        test_stream();
        test_async_reset();
        test_reset();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop();
        test_wrap();
        test_align();
        test_mem_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
